multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle RV32I core. It is the successor to the single-cycle main decoder: opcode decode is spread over per-instruction state sequences. It adds a memory ready/stall handshake, LUI/AUIPC support, illegal-opcode trapping and a retired-instruction counter. It sits beside the ALU decoder and drives the shared-ALU, single-memory datapath.

Parameters:
HAS_UPPER, 1, 1 enables LUI (0110111) and AUIPC (0010111); 0 treats them as illegal
TRAP_ON_ILLEGAL, 1, 1 makes illegal opcodes trap and halt; 0 skips them silently
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
op  in  7  instr[6:0] from the instruction register
br_taken  in  1  branch condition from the datapath comparator
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
MemWrite  out  1  write strobe, qualified by mem_req
AdrSrc  out  1  0=PC, 1=Result
IRWrite  out  1  load IR and OldPC
PCWrite  out  1  (Branch & br_taken) | PCUpdate
RegWrite  out  1  register file write
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1, 11=zero
ALUSrcB  out  2  00=rs2, 01=ImmExt, 10=constant 4
ALUOp  out  2  00=add, 01=sub/compare, 10=funct decode
ImmSrc  out  3  000=I, 001=S, 010=B, 011=J, 100=U
trap  out  1  sticky illegal-opcode flag
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (reset=0 at a clk edge): state<=FETCH, trap<=0, instret<=0. While reset=0, all outputs except instret and trap are forced to 0. A reset during MEMREAD or MEMWRITE aborts the access; there is no retire.
- Outputs not listed for a state are 0. ImmSrc is decoded combinationally from op in every state: lw/jalr/I-ALU=000, sw=001, B=010, jal=011, lui/auipc=100, else 000.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate equal mem_ready. On mem_ready go to DECODE; otherwise hold.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jal target into ALUOut). Next state by op: lw/sw->MEMADR, R->EXECR, I-ALU->EXECI, B->BRANCH, jal->JAL, jalr->JALR, lui->LUI, auipc->AUIPC, other->ILLEGAL.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw->MEMREAD, sw->MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Hold until mem_ready, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire, go to FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1, ResultSrc=00. Hold until mem_ready, then retire and go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, go to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire, go to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, retire, go to FETCH.
- JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00, go to JAL. The datapath clears target bit 0.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1, go to ALUWB (rd<=OldPC+4).
- LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00, go to ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, ALUOp=00, go to ALUWB.
- ILLEGAL:
  - TRAP_ON_ILLEGAL=1: trap<=1, state holds until reset, no memory requests.
  - TRAP_ON_ILLEGAL=0: go to FETCH with no retire; trap stays 0.
- Retire: instret increments by 1 in the retire cycle and wraps modulo 2^CNT_W.
- State count is fixed: 15 states, binary encoded.

Test Plan:
- lw, mem_ready low for 2 cycles in FETCH and 3 cycles in MEMREAD:
  - IRWrite and PCWrite pulse only in the mem_ready cycle.
  - Sequence is FETCH×3, DECODE, MEMADR, MEMREAD×4, MEMWB (RegWrite=1, ResultSrc=01).
  - instret 0->1.
- sw with mem_ready=1 always: 4 cycles; MemWrite=1 only in MEMWRITE with AdrSrc=1; RegWrite never asserted.
- beq in BRANCH state:
  - br_taken=1 -> PCWrite=1.
  - br_taken=0 -> PCWrite=0.
  - Both retire in 3 cycles.
- jalr: states DECODE, JALR, JAL (PCWrite=1, ALUSrcB=10), then ALUWB (RegWrite=1). Total 5 cycles.
- op=7'b1111111:
  - TRAP_ON_ILLEGAL=1 -> trap=1, mem_req stays 0 for 20 cycles, instret unchanged.
  - TRAP_ON_ILLEGAL=0 -> back to FETCH, trap=0.
  - HAS_UPPER=0 with lui -> same illegal behaviour.
- Counter wrap and reset:
  - CNT_W=4: 17 addi retire -> instret=1.
  - reset=0 asserted in MEMREAD -> next cycle state=FETCH, instret=0, mem_req=0 while reset=0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle main FSM and the datapath/memory.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic             br_taken;
  logic             mem_ready;
  logic             mem_req;
  logic             MemWrite;
  logic             AdrSrc;
  logic             IRWrite;
  logic             PCWrite;
  logic             RegWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [2:0]       ImmSrc;
  logic             trap;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, br_taken, mem_ready,
    output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, trap, instret
  );

  modport slave (
    output op, br_taken, mem_ready,
    input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, trap, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core with memory stall handshake,
// illegal-opcode trap and retired-instruction counter.
//
// state      | meaning
// S_FETCH    | read instr at PC, PC <= PC+4 on mem_ready
// S_DECODE   | read regs, ALUOut <= OldPC+imm
// S_MEMADR   | ALUOut <= rs1+imm for lw/sw
// S_MEMREAD  | load access, wait for mem_ready
// S_MEMWB    | rd <= Data, retire
// S_MEMWRITE | store access, retire on mem_ready
// S_EXECR    | R-type ALU op
// S_EXECI    | I-type ALU op
// S_ALUWB    | rd <= ALUOut, retire
// S_BRANCH   | compare, PC <= ALUOut if taken, retire
// S_JALR     | ALUOut <= rs1+imm
// S_JAL      | PC <= ALUOut, ALUResult = OldPC+4
// S_LUI      | ALUOut <= 0+imm
// S_AUIPC    | ALUOut <= OldPC+imm
// S_ILLEGAL  | trap and halt, or skip
module multicycle_ctrl #(
  parameter int HAS_UPPER       = 1,
  parameter int TRAP_ON_ILLEGAL = 1,
  parameter int CNT_W           = 32
) (
  input logic              clk,
  input logic              reset,
  multicycle_ctrl_if.master bus
);

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JALR, S_JAL, S_LUI, S_AUIPC, S_ILLEGAL
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       reg_write;
    logic       branch;
    logic       pc_update;
    logic       fetch;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctl_t;

  state_t           state;
  state_t           nxt;
  ctl_t             ctl_q;
  logic             trap_q;
  logic [CNT_W-1:0] instret_q;
  logic             retire;
  logic [2:0]       imm_src;
  logic             upper_ok;

  assign upper_ok = (HAS_UPPER != 0);

  function automatic ctl_t decode_ctl(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.mem_req = 1'b1; c.fetch = 1'b1; c.alu_src_b = 2'b10;
                        c.result_src = 2'b10; end
      S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      S_MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
      S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      S_MEMWRITE: begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.adr_src = 1'b1; end
      S_EXECR:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      S_EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      S_ALUWB:    c.reg_write = 1'b1;
      S_BRANCH:   begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
      S_JALR:     begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      S_JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
      S_LUI:      begin c.alu_src_a = 2'b11; c.alu_src_b = 2'b01; end
      S_AUIPC:    begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:    if (bus.mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXECR;
          OP_I:         nxt = S_EXECI;
          OP_B:         nxt = S_BRANCH;
          OP_JAL:       nxt = S_JAL;
          OP_JALR:      nxt = S_JALR;
          OP_LUI:       nxt = upper_ok ? S_LUI : S_ILLEGAL;
          OP_AUIPC:     nxt = upper_ok ? S_AUIPC : S_ILLEGAL;
          default:      nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   nxt = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (bus.mem_ready) nxt = S_MEMWB;
      S_MEMWRITE: if (bus.mem_ready) nxt = S_FETCH;
      S_MEMWB, S_ALUWB, S_BRANCH: nxt = S_FETCH;
      S_EXECR, S_EXECI, S_LUI, S_AUIPC: nxt = S_ALUWB;
      S_JALR:     nxt = S_JAL;
      S_JAL:      nxt = S_ALUWB;
      S_ILLEGAL:  nxt = (TRAP_ON_ILLEGAL != 0) ? S_ILLEGAL : S_FETCH;
      default:    nxt = S_FETCH;
    endcase
  end

  assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BRANCH) ||
                  ((state == S_MEMWRITE) && bus.mem_ready);

  // Control outputs are registered from the next state; only the
  // mem_ready / br_taken qualified strobes are combined afterwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_FETCH;
      ctl_q     <= decode_ctl(S_FETCH);
      trap_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      state <= nxt;
      ctl_q <= decode_ctl(nxt);
      if ((state == S_ILLEGAL) && (TRAP_ON_ILLEGAL != 0)) trap_q <= 1'b1;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    imm_src = 3'b000;
    case (bus.op)
      OP_SW:             imm_src = 3'b001;
      OP_B:              imm_src = 3'b010;
      OP_JAL:            imm_src = 3'b011;
      OP_LUI, OP_AUIPC:  imm_src = upper_ok ? 3'b100 : 3'b000;
      default:           imm_src = 3'b000;
    endcase
  end

  assign bus.mem_req   = reset & ctl_q.mem_req;
  assign bus.MemWrite  = reset & ctl_q.mem_write;
  assign bus.AdrSrc    = reset & ctl_q.adr_src;
  assign bus.IRWrite   = reset & ctl_q.fetch & bus.mem_ready;
  assign bus.PCWrite   = reset & ((ctl_q.branch & bus.br_taken) | ctl_q.pc_update |
                                  (ctl_q.fetch & bus.mem_ready));
  assign bus.RegWrite  = reset & ctl_q.reg_write;
  assign bus.ResultSrc = reset ? ctl_q.result_src : 2'b00;
  assign bus.ALUSrcA   = reset ? ctl_q.alu_src_a  : 2'b00;
  assign bus.ALUSrcB   = reset ? ctl_q.alu_src_b  : 2'b00;
  assign bus.ALUOp     = reset ? ctl_q.alu_op     : 2'b00;
  assign bus.ImmSrc    = reset ? imm_src          : 3'b000;
  assign bus.trap      = trap_q;
  assign bus.instret   = instret_q;

endmodule
